// File: rtl/stage_pkg.sv
// Shared definitions for the inter-stage pipeline registers.
package stage_pkg;

  // Occupancy state of a pipeline stage register.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b10
  } stage_state_e;

  // Default payload widths for each inter-stage boundary.
  // IF/ID : pc 32 + instr 32
  localparam int IF_ID_W = 32 + 32;
  // ID/EX : busa 32 + busb 32 + pc 32 + imm 32 + rd 5 + funct3 3 + op 7
  localparam int ID_EX_W = 32 + 32 + 32 + 32 + 5 + 3 + 7;
  // EX/MA : busc 32 + busb 32 + pc 32 + imm 32 + rd 5 + funct3 3 + op 7 = 143
  localparam int EX_MA_W = 32 + 32 + 32 + 32 + 5 + 3 + 7;
  // MA/WB : busc 32 + mem rdata 32 + rd 5 + funct3 3 + op 7
  localparam int MA_WB_W = 32 + 32 + 5 + 3 + 7;

  // Number of payloads held in a given state.
  function automatic logic [1:0] occ_of(stage_state_e s);
    logic [1:0] n;
    case (s)
      ONE:     n = 2'd1;
      FULL:    n = 2'd2;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for performance statistics; sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: step on inc unless already saturated.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/stage_pipe_skid.sv
// Inter-stage pipeline register with valid/ready handshake, optional
// two-entry skid buffer, flush and a back-pressure cycle counter.
//
// state | meaning
// EMPTY | nothing held, out_valid low
// ONE   | one payload in main register, presented downstream
// FULL  | main presented, next payload parked in skid (SKID=1 only)
module stage_pipe_skid
  import stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic accept;
  logic consume;
  logic stall;

  assign accept  = in_valid & in_ready;
  assign consume = out_valid & out_ready;
  assign stall   = in_valid & ~in_ready;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall),
    .count (stall_cnt)
  );

  generate
    if (SKID != 0) begin : g_skid
      stage_state_e      state_q, state_d;
      logic [DATA_W-1:0] main_q, main_d;
      logic [DATA_W-1:0] skid_q, skid_d;
      logic              in_ready_q, in_ready_d;

      // State, data and registered ready flops.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state_q    <= EMPTY;
          main_q     <= '0;
          skid_q     <= '0;
          in_ready_q <= 1'b1;
        end else begin
          state_q    <= state_d;
          main_q     <= main_d;
          skid_q     <= skid_d;
          in_ready_q <= in_ready_d;
        end
      end

      // Next state and data movement; flush overrides and freezes data.
      always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
          EMPTY: begin
            if (accept) begin
              state_d = ONE;
              main_d  = in_data;
            end
          end
          ONE: begin
            if (accept && consume) begin
              main_d = in_data;
            end else if (consume) begin
              state_d = EMPTY;
            end else if (accept) begin
              state_d = FULL;
              skid_d  = in_data;
            end
          end
          FULL: begin
            if (consume) begin
              state_d = ONE;
              main_d  = skid_q;
            end
          end
          default: state_d = EMPTY;
        endcase
        if (flush) begin
          state_d = EMPTY;
          main_d  = main_q;
          skid_d  = skid_q;
        end
        // Ready is precomputed so the port comes straight off a flop.
        in_ready_d = (state_d != FULL);
      end

      // Outputs decoded from registered state only.
      always_comb begin
        out_valid = (state_q != EMPTY);
        occupancy = occ_of(state_q);
        in_ready  = in_ready_q;
        out_data  = main_q;
      end
    end else begin : g_noskid
      stage_state_e      state_q, state_d;
      logic [DATA_W-1:0] main_q, main_d;

      // State and data flops.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state_q <= EMPTY;
          main_q  <= '0;
        end else begin
          state_q <= state_d;
          main_q  <= main_d;
        end
      end

      // Next state: refill on accept, drain on consume, flush wins.
      always_comb begin
        state_d = state_q;
        main_d  = main_q;
        if (accept) begin
          state_d = ONE;
          main_d  = in_data;
        end else if (consume) begin
          state_d = EMPTY;
        end
        if (flush) begin
          state_d = EMPTY;
          main_d  = main_q;
        end
      end

      // Outputs; ready passes out_ready through combinationally.
      always_comb begin
        out_valid = (state_q != EMPTY);
        occupancy = occ_of(state_q);
        in_ready  = (state_q == EMPTY) | out_ready;
        out_data  = main_q;
      end
    end
  endgenerate

endmodule

// File: tb/tb_stage_pipe_skid.sv
// Directed bench for stage_pipe_skid: SKID=1 (a), SKID=0 (b), and a SKID=1
// copy with a 4-bit stall counter (c) sharing a's inputs.
module tb_stage_pipe_skid;

  typedef struct {
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        fl;
    logic        eov;
    logic [31:0] eod;
    logic        eir;
    logic [1:0]  eocc;
    logic [15:0] est;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        a_iv, a_ir, a_fl, a_ov, a_ordy;
  logic [31:0] a_d, a_od;
  logic [1:0]  a_occ;
  logic [15:0] a_st;

  logic        c_ir, c_ov;
  logic [31:0] c_od;
  logic [1:0]  c_occ;
  logic [3:0]  c_st;

  logic        b_iv, b_ir, b_fl, b_ov, b_ordy;
  logic [31:0] b_d, b_od;
  logic [1:0]  b_occ;
  logic [15:0] b_st;

  int n_cmp = 0;
  int n_bad = 0;
  logic saw_aa = 1'b0;

  vec_t tbl_a[17];
  vec_t tbl_b[7];

  always #5 clk = ~clk;

  stage_pipe_skid #(.DATA_W(32), .SKID(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_ir), .in_data(a_d),
    .flush(a_fl), .out_valid(a_ov), .out_ready(a_ordy), .out_data(a_od),
    .occupancy(a_occ), .stall_cnt(a_st)
  );

  stage_pipe_skid #(.DATA_W(32), .SKID(0), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir), .in_data(b_d),
    .flush(b_fl), .out_valid(b_ov), .out_ready(b_ordy), .out_data(b_od),
    .occupancy(b_occ), .stall_cnt(b_st)
  );

  stage_pipe_skid #(.DATA_W(32), .SKID(1), .CNT_W(4)) dut_c (
    .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(c_ir), .in_data(a_d),
    .flush(a_fl), .out_valid(c_ov), .out_ready(a_ordy), .out_data(c_od),
    .occupancy(c_occ), .stall_cnt(c_st)
  );

  always @(negedge clk) begin
    if (a_ov && (a_od == 32'hAA)) saw_aa = 1'b1;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(logic iv, logic [31:0] d, logic ordy, logic fl,
                              logic eov, logic [31:0] eod, logic eir,
                              logic [1:0] eocc, logic [15:0] est);
    vec_t v;
    v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl;
    v.eov = eov; v.eod = eod; v.eir = eir; v.eocc = eocc; v.est = est;
    return v;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    a_iv = 1'b0; a_d = '0; a_fl = 1'b0; a_ordy = 1'b0;
    b_iv = 1'b0; b_d = '0; b_fl = 1'b0; b_ordy = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_a_table();
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      a_iv = tbl_a[i].iv; a_d = tbl_a[i].d; a_ordy = tbl_a[i].ordy; a_fl = tbl_a[i].fl;
      #1;
      chk($sformatf("tblA[%0d].out_valid", i), 64'(a_ov), 64'(tbl_a[i].eov));
      chk($sformatf("tblA[%0d].out_data", i), 64'(a_od), 64'(tbl_a[i].eod));
      chk($sformatf("tblA[%0d].in_ready", i), 64'(a_ir), 64'(tbl_a[i].eir));
      chk($sformatf("tblA[%0d].occupancy", i), 64'(a_occ), 64'(tbl_a[i].eocc));
      chk($sformatf("tblA[%0d].stall_cnt", i), 64'(a_st), 64'(tbl_a[i].est));
    end
  endtask

  task automatic run_b_table();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      b_iv = tbl_b[i].iv; b_d = tbl_b[i].d; b_ordy = tbl_b[i].ordy; b_fl = tbl_b[i].fl;
      #1;
      chk($sformatf("tblB[%0d].out_valid", i), 64'(b_ov), 64'(tbl_b[i].eov));
      chk($sformatf("tblB[%0d].out_data", i), 64'(b_od), 64'(tbl_b[i].eod));
      chk($sformatf("tblB[%0d].in_ready", i), 64'(b_ir), 64'(tbl_b[i].eir));
      chk($sformatf("tblB[%0d].occupancy", i), 64'(b_occ), 64'(tbl_b[i].eocc));
      chk($sformatf("tblB[%0d].stall_cnt", i), 64'(b_st), 64'(tbl_b[i].est));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // SKID=1: back-pressure fill, drain in order, then flush cases.
    //                 iv    d       ordy  fl    eov   eod     eir   eocc  est
    tbl_a[0]  = mk(1'b1, 32'h1,  1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 2'd0, 16'd0);
    tbl_a[1]  = mk(1'b1, 32'h2,  1'b0, 1'b0, 1'b1, 32'h1,  1'b1, 2'd1, 16'd0);
    tbl_a[2]  = mk(1'b1, 32'h3,  1'b0, 1'b0, 1'b1, 32'h1,  1'b0, 2'd2, 16'd0);
    tbl_a[3]  = mk(1'b1, 32'h3,  1'b0, 1'b0, 1'b1, 32'h1,  1'b0, 2'd2, 16'd1);
    tbl_a[4]  = mk(1'b1, 32'h3,  1'b1, 1'b0, 1'b1, 32'h1,  1'b0, 2'd2, 16'd2);
    tbl_a[5]  = mk(1'b1, 32'h3,  1'b1, 1'b0, 1'b1, 32'h2,  1'b1, 2'd1, 16'd3);
    tbl_a[6]  = mk(1'b1, 32'h4,  1'b1, 1'b0, 1'b1, 32'h3,  1'b1, 2'd1, 16'd3);
    tbl_a[7]  = mk(1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 32'h4,  1'b1, 2'd1, 16'd3);
    tbl_a[8]  = mk(1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 32'h4,  1'b1, 2'd0, 16'd3);
    tbl_a[9]  = mk(1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 32'h4,  1'b1, 2'd0, 16'd3);
    tbl_a[10] = mk(1'b1, 32'h11, 1'b0, 1'b0, 1'b1, 32'h10, 1'b1, 2'd1, 16'd3);
    tbl_a[11] = mk(1'b1, 32'hAA, 1'b0, 1'b1, 1'b1, 32'h10, 1'b0, 2'd2, 16'd3);
    tbl_a[12] = mk(1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 32'h10, 1'b1, 2'd0, 16'd4);
    tbl_a[13] = mk(1'b1, 32'h20, 1'b1, 1'b1, 1'b0, 32'h10, 1'b1, 2'd0, 16'd4);
    tbl_a[14] = mk(1'b1, 32'h21, 1'b1, 1'b0, 1'b0, 32'h10, 1'b1, 2'd0, 16'd4);
    tbl_a[15] = mk(1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 32'h21, 1'b1, 2'd1, 16'd4);
    tbl_a[16] = mk(1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 32'h21, 1'b1, 2'd0, 16'd4);
    // SKID=0: combinational ready, flush while offered.
    tbl_b[0]  = mk(1'b1, 32'h31, 1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 2'd0, 16'd0);
    tbl_b[1]  = mk(1'b1, 32'h32, 1'b0, 1'b0, 1'b1, 32'h31, 1'b0, 2'd1, 16'd0);
    tbl_b[2]  = mk(1'b1, 32'h32, 1'b1, 1'b0, 1'b1, 32'h31, 1'b1, 2'd1, 16'd1);
    tbl_b[3]  = mk(1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 32'h32, 1'b0, 2'd1, 16'd1);
    tbl_b[4]  = mk(1'b1, 32'h33, 1'b0, 1'b1, 1'b1, 32'h32, 1'b0, 2'd1, 16'd1);
    tbl_b[5]  = mk(1'b1, 32'h34, 1'b0, 1'b1, 1'b0, 32'h32, 1'b1, 2'd0, 16'd2);
    tbl_b[6]  = mk(1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 32'h32, 1'b1, 2'd0, 16'd2);

    // Reset values and a single transfer in both modes.
    do_reset();
    #1;
    chk("rst.a.out_valid", 64'(a_ov), 64'd0);
    chk("rst.a.out_data", 64'(a_od), 64'd0);
    chk("rst.a.occupancy", 64'(a_occ), 64'd0);
    chk("rst.a.stall_cnt", 64'(a_st), 64'd0);
    chk("rst.a.in_ready", 64'(a_ir), 64'd1);
    chk("rst.b.in_ready", 64'(b_ir), 64'd1);
    chk("rst.b.out_valid", 64'(b_ov), 64'd0);
    @(negedge clk);
    a_iv = 1'b1; a_d = 32'hDEADBEEF; a_ordy = 1'b1;
    b_iv = 1'b1; b_d = 32'hDEADBEEF; b_ordy = 1'b1;
    @(negedge clk);
    a_iv = 1'b0; b_iv = 1'b0;
    #1;
    chk("single.a.out_valid", 64'(a_ov), 64'd1);
    chk("single.a.out_data", 64'(a_od), 64'hDEADBEEF);
    chk("single.b.out_valid", 64'(b_ov), 64'd1);
    chk("single.b.out_data", 64'(b_od), 64'hDEADBEEF);
    @(negedge clk);
    #1;
    chk("single.a.drained", 64'(a_ov), 64'd0);
    chk("single.b.drained", 64'(b_ov), 64'd0);
    chk("single.a.stall_cnt", 64'(a_st), 64'd0);

    // Directed tables.
    do_reset();
    run_a_table();
    run_b_table();
    chk("flush.0xAA_never_out", 64'(saw_aa), 64'd0);

    // Full-rate stream of 100 payloads through both modes.
    do_reset();
    for (int i = 0; i <= 101; i++) begin
      @(negedge clk);
      a_iv = (i < 100); a_d = 32'h1000 + i; a_ordy = 1'b1;
      b_iv = (i < 100); b_d = 32'h1000 + i; b_ordy = 1'b1;
      #1;
      chk($sformatf("stream[%0d].a.in_ready", i), 64'(a_ir), 64'd1);
      chk($sformatf("stream[%0d].b.in_ready", i), 64'(b_ir), 64'd1);
      chk($sformatf("stream[%0d].a.occupancy", i), 64'(a_occ),
          (i >= 1 && i <= 100) ? 64'd1 : 64'd0);
      chk($sformatf("stream[%0d].b.out_valid", i), 64'(b_ov),
          (i >= 1 && i <= 100) ? 64'd1 : 64'd0);
      chk($sformatf("stream[%0d].a.out_valid", i), 64'(a_ov),
          (i >= 1 && i <= 100) ? 64'd1 : 64'd0);
      if (i >= 1 && i <= 100) begin
        chk($sformatf("stream[%0d].a.out_data", i), 64'(a_od), 64'(32'h1000 + i - 1));
        chk($sformatf("stream[%0d].b.out_data", i), 64'(b_od), 64'(32'h1000 + i - 1));
      end
    end
    chk("stream.a.stall_cnt", 64'(a_st), 64'd0);

    // Asynchronous reset while FULL, between edges.
    do_reset();
    @(negedge clk);
    a_iv = 1'b1; a_d = 32'h41; a_ordy = 1'b0;
    @(negedge clk);
    a_d = 32'h42;
    @(negedge clk);
    a_d = 32'h43;
    @(negedge clk);
    #1;
    chk("arst.pre.occupancy", 64'(a_occ), 64'd2);
    chk("arst.pre.stall_cnt", 64'(a_st), 64'd1);
    rst = 1'b1;
    #1;
    chk("arst.out_valid", 64'(a_ov), 64'd0);
    chk("arst.occupancy", 64'(a_occ), 64'd0);
    chk("arst.stall_cnt", 64'(a_st), 64'd0);
    chk("arst.in_ready", 64'(a_ir), 64'd1);
    chk("arst.out_data", 64'(a_od), 64'd0);
    a_iv = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    a_iv = 1'b1; a_d = 32'h55;
    @(negedge clk);
    a_iv = 1'b0;
    #1;
    chk("arst.first_accept.out_valid", 64'(a_ov), 64'd1);
    chk("arst.first_accept.out_data", 64'(a_od), 64'h55);

    // Counter saturation: 30 cycles offered with no downstream ready.
    do_reset();
    @(negedge clk);
    a_iv = 1'b1; a_d = 32'h77; a_ordy = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk);
    #1;
    chk("sat.c.stall_cnt", 64'(c_st), 64'd15);
    chk("sat.a.stall_cnt", 64'(a_st), 64'd28);
    chk("sat.c.occupancy", 64'(c_occ), 64'd2);
    chk("sat.c.out_data", 64'(c_od), 64'h77);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stage_pipe_skid.md
# stage_pipe_skid

Parametrised successor to the fixed-field inter-stage pipeline registers between the datapath stages (IF/ID, ID/EX, EX/MA, MA/WB). It carries an opaque payload of DATA_W bits with a valid/ready handshake instead of a bare enable. An optional two-entry skid buffer breaks the combinational ready path. Flush support drops wrong-path instructions. A saturating counter records back-pressure cycles for performance analysis.

## Interface
Parameters:
- DATA_W, 32: payload width in bits. The instantiating stage concatenates its fields (bus, imm, pc, rd, funct3, op…).
- SKID, 1: selects the ready path.
  - 1: two-entry skid buffer with registered in_ready.
  - 0: single register with combinational in_ready.
- CNT_W, 16: stall counter width.

Ports:
- clk, input, 1: single clock. All state changes on the rising edge.
- rst, input, 1: reset, asynchronous and active-high.
- in_valid, input, 1: upstream presents a payload.
- in_ready, output, 1: block accepts the payload this cycle.
- in_data, input, DATA_W: upstream payload.
- flush, input, 1: discard all held entries and any payload offered this cycle.
- out_valid, output, 1: out_data holds a valid payload.
- out_ready, input, 1: downstream consumes the payload this cycle.
- out_data, output, DATA_W: payload to downstream, driven directly from the main register.
- occupancy, output, 2: number of held entries, 0..2.
- stall_cnt, output, CNT_W: saturating count of back-pressure cycles.

## Operation
- Handshake terms:
  - Accept = in_valid & in_ready.
  - Consume = out_valid & out_ready.
- Ordering: payloads leave in acceptance order. None are dropped except on flush, and none are duplicated.
- State machine (SKID=1): states EMPTY, ONE, FULL.
  - out_valid = (state != EMPTY).
  - in_ready = (state != FULL), registered.
  - occupancy: EMPTY=0, ONE=1, FULL=2.
- Transitions from EMPTY:
  - Accept → ONE, main <= in_data.
  - Otherwise stay in EMPTY.
- Transitions from ONE:
  - Accept & consume → stay in ONE, main <= in_data.
  - Consume only → EMPTY.
  - Accept only → FULL, skid <= in_data.
  - Neither → hold.
- Transitions from FULL (in_ready=0):
  - Consume → ONE, main <= skid.
  - Otherwise hold both registers.
- SKID=0:
  - No FULL state and no skid register.
  - in_ready = !out_valid | out_ready, combinational.
  - occupancy is 0 or 1.
- Flush:
  - Highest priority. Next state EMPTY regardless of accept or consume.
  - A payload offered in the flush cycle is dropped, even though in_ready may read 1.
  - A payload read in the flush cycle is still delivered if consumed; flush does not cancel a handshake in its own cycle.
  - Data registers keep their contents (contents are don't-care while invalid).
- Stall counter:
  - Increments when in_valid & !in_ready.
  - Saturates at 2^CNT_W−1.
  - Cleared only by rst; flush does not clear it.

## Timing
- Latency: a payload accepted at edge N is visible on out_data with out_valid=1 after edge N.
- Throughput: one payload per cycle while out_ready=1, in both SKID modes.
- SKID=1 ready timing: in_ready deasserts the cycle after the buffer becomes FULL. In_ready reasserts the cycle after the first consume from FULL.
- Reset values: state EMPTY, out_valid 0, out_data 0, occupancy 0, stall_cnt 0, in_ready 1.
  - The in_ready reset value applies to both SKID modes, since out_valid=0.
- Reset mid-operation: all entries are discarded immediately (asynchronously), without waiting for an edge.
- Reset release:
  - The first accept is possible at the first rising edge after rst falls.
  - rst is required to deassert synchronously to clk.
- Data stability: out_data is unchanged while out_valid & !out_ready.

## Structure
- Shared package stage_pkg holds:
  - the state type and encoding: EMPTY=2'b00, ONE=2'b01, FULL=2'b10;
  - the default DATA_W constants for each inter-stage payload, e.g. the EX/MA payload = busc 32 + busb 32 + pc 32 + imm 32 + rd 5 + funct3 3 + op 7 = 143.
- Sub-module sat_counter (parameter W; ports clk, rst, inc, count) implements stall_cnt and is reused for other performance counters.
- The SKID mode is selected with a generate on the SKID parameter inside stage_pipe_skid, not as a separate module.

## Test plan
- Reset and single transfer: rst pulse; in_data=32'hDEADBEEF with in_valid=1 and out_ready=1 for one cycle → out_valid=1 with 32'hDEADBEEF one cycle later, then out_valid=0; stall_cnt=0.
- Back-pressure (SKID=1): stream 0x1,0x2,0x3,0x4 with out_ready=0 → 0x1 and 0x2 held, occupancy=2, in_ready=0; stall_cnt counts each stalled cycle. Then out_ready=1 → outputs 0x1,0x2,0x3,0x4 in order with no loss.
- Full-rate stream: 100 consecutive payloads with out_ready=1 in both SKID modes → 100 outputs, one per cycle, in order, occupancy never 2.
- Flush in FULL with in_valid=1 (payload 0xAA) → next cycle occupancy=0 and out_valid=0; 0xAA never appears at the output.
- Asynchronous reset mid-stream: assert rst between edges while FULL → out_valid, occupancy and stall_cnt go to 0 before the next edge.
- Saturation: CNT_W=4, hold in_valid=1 and out_ready=0 for 30 cycles → stall_cnt stops at 15.
